// File: rtl/lcd_text_buffer_if.sv
// Byte-stream input and LCD-driver read port of lcd_text_buffer.
// Handshake: a byte transfers on a posedge where in_valid && in_ready; in_data may change while in_ready is low.
interface lcd_text_buffer_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] addr;
    logic       rd;
    logic [7:0] data;

    modport master (
        output in_data, in_valid, addr, rd,
        input  in_ready, data
    );

    modport slave (
        input  in_data, in_valid, addr, rd,
        output in_ready, data
    );
endinterface

// File: rtl/lcd_text_buffer.sv
// 2x16 character frame buffer with cursor engine feeding the SC1602 refresh driver.
// Optional feature macro: LCD_TEXT_BUFFER_SCROLL_EN (line-1 wrap/LF scrolls instead of homing).
module lcd_text_buffer #(
    parameter logic [7:0] FILL_CHAR = 8'h20,
    parameter logic [7:0] ESC_CODE  = 8'h1B
) (
    input  logic               clk,
    input  logic               resetn,
    lcd_text_buffer_if.slave   bus,
    output logic               cursor_line,
    output logic [3:0]         cursor_col,
    output logic               busy,
    output logic [1:0]         dbg_state_o
);

`ifdef LCD_TEXT_BUFFER_SCROLL_EN
    typedef enum logic [1:0] {IDLE, ESC, CLEAR, SCROLL} state_t;
`else
    typedef enum logic [1:0] {IDLE, ESC, CLEAR} state_t;
`endif

    state_t      state_q, state_d;
    logic        line_q, line_d;
    logic [3:0]  col_q, col_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [7:0]  cells_q [32];

    logic        wr_en;
    logic [4:0]  wr_idx;
    logic [7:0]  wr_data;
    logic        accept;
    logic        printable;
    logic        line1_wrap;
    logic [4:0]  rd_idx;
    logic        rd_in_map;
    wire         unused_rd = bus.rd;

    assign bus.in_ready = resetn && (state_q == IDLE || state_q == ESC);
`ifdef LCD_TEXT_BUFFER_SCROLL_EN
    assign busy = resetn && (state_q == CLEAR || state_q == SCROLL);
`else
    assign busy = resetn && (state_q == CLEAR);
`endif
    assign accept      = bus.in_valid && bus.in_ready;
    assign printable   = (bus.in_data >= 8'h20 && bus.in_data <= 8'h7E) || (bus.in_data >= 8'hA0);
    assign cursor_line = line_q;
    assign cursor_col  = col_q;
    assign dbg_state_o = state_q;

    // Driver address map: line 0 at 0x00-0x0F, line 1 at 0x40-0x4F; the rest reads as blank.
    assign rd_in_map = !bus.addr[7] && (bus.addr[5:4] == 2'b00);
    assign rd_idx    = {bus.addr[6], bus.addr[3:0]};
    assign bus.data  = rd_in_map ? cells_q[rd_idx] : FILL_CHAR;

    always_comb begin
        state_d    = state_q;
        line_d     = line_q;
        col_d      = col_q;
        cnt_d      = cnt_q;
        wr_en      = 1'b0;
        wr_idx     = {line_q, col_q};
        wr_data    = bus.in_data;
        line1_wrap = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (printable) begin
                        wr_en = 1'b1;
                        if (col_q != 4'd15) begin
                            col_d = col_q + 4'd1;
                        end else if (!line_q) begin
                            line_d = 1'b1;
                            col_d  = 4'd0;
                        end else begin
                            line1_wrap = 1'b1;
                        end
                    end else if (bus.in_data == 8'h0D) begin
                        col_d = 4'd0;
                    end else if (bus.in_data == 8'h0A) begin
                        col_d = 4'd0;
                        if (!line_q) begin
                            line_d = 1'b1;
                        end else begin
                            line1_wrap = 1'b1;
                        end
                    end else if (bus.in_data == 8'h08) begin
                        col_d = (col_q == 4'd0) ? 4'd0 : col_q - 4'd1;
                    end else if (bus.in_data == 8'h0C) begin
                        state_d = CLEAR;
                        cnt_d   = 5'd0;
                    end else if (bus.in_data == ESC_CODE) begin
                        state_d = ESC;
                    end
                end
            end
            ESC: begin
                if (accept) begin
                    line_d  = bus.in_data[4];
                    col_d   = bus.in_data[3:0];
                    state_d = IDLE;
                end
            end
            CLEAR: begin
                wr_en   = 1'b1;
                wr_idx  = cnt_q;
                wr_data = FILL_CHAR;
                if (cnt_q == 5'd31) begin
                    line_d  = 1'b0;
                    col_d   = 4'd0;
                    cnt_d   = 5'd0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
`ifdef LCD_TEXT_BUFFER_SCROLL_EN
            SCROLL: begin
                if (cnt_q[3:0] == 4'd15) begin
                    line_d  = 1'b1;
                    col_d   = 4'd0;
                    cnt_d   = 5'd0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
`endif
            default: state_d = IDLE;
        endcase

        // Running off the end of line 1 either scrolls or homes the cursor.
        if (line1_wrap) begin
`ifdef LCD_TEXT_BUFFER_SCROLL_EN
            state_d = SCROLL;
            cnt_d   = 5'd0;
`else
            line_d = 1'b0;
            col_d  = 4'd0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            line_q  <= 1'b0;
            col_q   <= 4'd0;
            cnt_q   <= 5'd0;
            for (int i = 0; i < 32; i++) begin
                cells_q[i] <= FILL_CHAR;
            end
        end else begin
            state_q <= state_d;
            line_q  <= line_d;
            col_q   <= col_d;
            cnt_q   <= cnt_d;
            if (wr_en) begin
                cells_q[wr_idx] <= wr_data;
            end
`ifdef LCD_TEXT_BUFFER_SCROLL_EN
            if (state_q == SCROLL) begin
                cells_q[{1'b0, cnt_q[3:0]}] <= cells_q[{1'b1, cnt_q[3:0]}];
                cells_q[{1'b1, cnt_q[3:0]}] <= FILL_CHAR;
            end
`endif
        end
    end

endmodule

// File: tb/tb_lcd_text_buffer.sv
// Directed bench for lcd_text_buffer: text entry, cursor control, clear, line-1 wrap/scroll, reset abort.
module tb_lcd_text_buffer;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       cursor_line;
    logic [3:0] cursor_col;
    logic       busy;
    logic [1:0] dbg_state;

    int         n_checks = 0;
    int         n_errors = 0;
    int         ready_bad = 0;
    int         cyc;
    logic [7:0] exp_q [$];

    always #5 clk = ~clk;

    lcd_text_buffer_if bus ();

    lcd_text_buffer dut (
        .clk         (clk),
        .resetn      (resetn),
        .bus         (bus.slave),
        .cursor_line (cursor_line),
        .cursor_col  (cursor_col),
        .busy        (busy),
        .dbg_state_o (dbg_state)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        int n = 0;
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 200) begin
            sync();
            n++;
        end
        if (n >= 200) check("send_timeout", 32'd0, 32'd1);
        sync();
        bus.in_valid = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [7:0] a, input logic [7:0] exp);
        bus.addr = a;
        bus.rd   = 1'b1;
        #1;
        check(tag, {24'd0, bus.data}, {24'd0, exp});
        bus.rd = 1'b0;
    endtask

    task automatic cur_chk(input string tag, input logic l, input logic [3:0] c);
        check({tag, "_line"}, {31'd0, cursor_line}, {31'd0, l});
        check({tag, "_col"}, {28'd0, cursor_col}, {28'd0, c});
    endtask

    task automatic wait_busy(output int cycles);
        cycles = 0;
        while (busy && cycles < 100) begin
            if (bus.in_ready) ready_bad++;
            sync();
            cycles++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.in_data  = 8'h00;
        bus.in_valid = 1'b0;
        bus.addr     = 8'h00;
        bus.rd       = 1'b0;

        // Reset
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready_low", {31'd0, bus.in_ready}, 32'd0);
        check("rst_busy_low", {31'd0, busy}, 32'd0);
        resetn = 1'b1;
        #1;
        check("rst_ready_rel", {31'd0, bus.in_ready}, 32'd1);
        cur_chk("rst_cur", 1'b0, 4'd0);
        rd_chk("rst_c00", 8'h00, 8'h20);
        rd_chk("rst_c4f", 8'h4F, 8'h20);
        sync();

        // "HI" back to back
        send(8'h48);
        check("hi_ready", {31'd0, bus.in_ready}, 32'd1);
        send(8'h49);
        check("hi_ready2", {31'd0, bus.in_ready}, 32'd1);
        rd_chk("hi_c00", 8'h00, 8'h48);
        rd_chk("hi_c01", 8'h01, 8'h49);
        rd_chk("hi_c02", 8'h02, 8'h20);
        cur_chk("hi_cur", 1'b0, 4'd2);
        sync();

        // 17 x 'A' from home crosses into line 1
        send(8'h1B);
        send(8'h00);
        repeat (17) send(8'h41);
        cur_chk("a17_cur", 1'b1, 4'd1);
        for (int i = 0; i < 16; i++) exp_q.push_back(8'h41);
        exp_q.push_back(8'h41);
        exp_q.push_back(8'h20);
        for (int i = 0; i < 16; i++) rd_chk("a17_line0", 8'(i), exp_q.pop_front());
        rd_chk("a17_c40", 8'h40, exp_q.pop_front());
        rd_chk("a17_c41", 8'h41, exp_q.pop_front());
        sync();

        // ESC positioning and out-of-map reads
        send(8'h1B);
        send(8'h1A);
        send(8'h5A);
        rd_chk("esc_c4a", 8'h4A, 8'h5A);
        cur_chk("esc_cur", 1'b1, 4'd11);
        rd_chk("oom_20", 8'h20, 8'h20);
        rd_chk("oom_80", 8'h80, 8'h20);
        rd_chk("oom_50", 8'h50, 8'h20);
        sync();

        // BS / CR / LF / discarded bytes
        send(8'h1B);
        send(8'hE5);
        cur_chk("esc_hi_bits", 1'b0, 4'd5);
        send(8'h08);
        cur_chk("bs_cur", 1'b0, 4'd4);
        send(8'h0D);
        cur_chk("cr_cur", 1'b0, 4'd0);
        send(8'h08);
        cur_chk("bs_sat", 1'b0, 4'd0);
        send(8'h0A);
        cur_chk("lf_cur", 1'b1, 4'd0);
        send(8'h01);
        send(8'h7F);
        send(8'h9F);
        cur_chk("discard_cur", 1'b1, 4'd0);
        rd_chk("discard_c40", 8'h40, 8'h41);
        send(8'hA5);
        rd_chk("hi_code_c40", 8'h40, 8'hA5);
        cur_chk("hi_code_cur", 1'b1, 4'd1);
        sync();

        // Fill 31 cells, then clear with a byte held valid throughout
        send(8'h1B);
        send(8'h00);
        repeat (31) send(8'h42);
        cur_chk("fill_cur", 1'b1, 4'd15);
        rd_chk("fill_c00", 8'h00, 8'h42);
        rd_chk("fill_c4e", 8'h4E, 8'h42);
        sync();
        send(8'h0C);
        bus.in_data  = 8'h43;
        bus.in_valid = 1'b1;
        ready_bad    = 0;
        wait_busy(cyc);
        check("clr_cycles", cyc, 32'd32);
        check("clr_ready_low", ready_bad, 32'd0);
        check("clr_ready_after", {31'd0, bus.in_ready}, 32'd1);
        cur_chk("clr_cur", 1'b0, 4'd0);
        sync();
        bus.in_valid = 1'b0;
        cur_chk("clr_held_cur", 1'b0, 4'd1);
        rd_chk("clr_held_c00", 8'h00, 8'h43);
        for (int i = 1; i < 32; i++)
            rd_chk("clr_cell", (i < 16) ? 8'(i) : 8'(8'h40 + i - 16), 8'h20);
        sync();

        // Wrap off the end of line 1
        send(8'h1B);
        send(8'h10);
        send(8'h58);
        send(8'h59);
        send(8'h1B);
        send(8'h1F);
        send(8'h51);
`ifdef LCD_TEXT_BUFFER_SCROLL_EN
        ready_bad = 0;
        wait_busy(cyc);
        check("scr_cycles", cyc, 32'd16);
        check("scr_ready_low", ready_bad, 32'd0);
        cur_chk("scr_cur", 1'b1, 4'd0);
        rd_chk("scr_c00", 8'h00, 8'h58);
        rd_chk("scr_c01", 8'h01, 8'h59);
        rd_chk("scr_c02", 8'h02, 8'h20);
        rd_chk("scr_c0f", 8'h0F, 8'h51);
        rd_chk("scr_c40", 8'h40, 8'h20);
        rd_chk("scr_c41", 8'h41, 8'h20);
        rd_chk("scr_c4f", 8'h4F, 8'h20);
        sync();
`else
        check("wrap_busy", {31'd0, busy}, 32'd0);
        cur_chk("wrap_cur", 1'b0, 4'd0);
        rd_chk("wrap_c00", 8'h00, 8'h43);
        rd_chk("wrap_c01", 8'h01, 8'h20);
        rd_chk("wrap_c40", 8'h40, 8'h58);
        rd_chk("wrap_c41", 8'h41, 8'h59);
        rd_chk("wrap_c4f", 8'h4F, 8'h51);
        sync();
        send(8'h1B);
        send(8'h13);
        send(8'h0A);
        cur_chk("lf1_cur", 1'b0, 4'd0);
        sync();
`endif

        // Reset in the middle of CLEAR
        send(8'h0C);
        repeat (5) sync();
        check("mid_clr_busy", {31'd0, busy}, 32'd1);
        resetn = 1'b0;
        #1;
        check("mid_clr_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_clr_rst_ready", {31'd0, bus.in_ready}, 32'd0);
        sync();
        resetn = 1'b1;
        #1;
        check("mid_clr_rel_busy", {31'd0, busy}, 32'd0);
        check("mid_clr_rel_ready", {31'd0, bus.in_ready}, 32'd1);
        check("mid_clr_state", {30'd0, dbg_state}, 32'd0);
        cur_chk("mid_clr_cur", 1'b0, 4'd0);
        sync();

        // Reset in the middle of ESC
        send(8'h4B);
        rd_chk("pre_esc_c00", 8'h00, 8'h4B);
        sync();
        send(8'h1B);
        check("esc_state", {30'd0, dbg_state}, 32'd1);
        resetn = 1'b0;
        sync();
        resetn = 1'b1;
        #1;
        check("mid_esc_ready", {31'd0, bus.in_ready}, 32'd1);
        rd_chk("mid_esc_c00", 8'h00, 8'h20);
        cur_chk("mid_esc_cur", 1'b0, 4'd0);
        sync();
        send(8'h15);
        cur_chk("post_rst_discard", 1'b0, 4'd0);
        send(8'h4D);
        rd_chk("post_rst_c00", 8'h00, 8'h4D);
        cur_chk("post_rst_cur", 1'b0, 4'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/lcd_text_buffer.md
Name: lcd_text_buffer

Overview:
- Character frame buffer and cursor engine that sits directly upstream of the SC1602 LCD refresh driver.
- Accepts a byte stream (ASCII/HD44780 codes plus control codes) over a valid/ready handshake, keeps a cursor, and writes into a 2x16 cell store.
- Serves the driver's read port (addr/rd/data) using the driver's address map: line 0 at 0x00-0x0F, line 1 at 0x40-0x4F.

Parameters:
FILL_CHAR, 8'h20, value written by reset, clear and scroll-blanking
ESC_CODE, 8'h1B, control byte introducing a cursor-position byte

Ports:
clk  input  1  system clock
resetn  input  1  synchronous reset, active-low
in_data  input  8  character/control byte
in_valid  input  1  in_data valid
in_ready  output  1  block can accept a byte this cycle
addr  input  8  read address from LCD driver
rd  input  1  read strobe from LCD driver (informational; read path is always active)
data  output  8  cell contents at addr
cursor_line  output  1  current cursor line
cursor_col  output  4  current cursor column
busy  output  1  high in CLEAR or SCROLL

Behaviour:
- Clock and reset (already decided): one clock, clk; reset resetn is synchronous, active-low. All state updates on posedge clk only.
- Reset (resetn low at a posedge):
  - all 32 cells <= FILL_CHAR; state <= IDLE; cursor 0/0.
  - in_ready=0 and busy=0 while resetn is low; in_ready=1 from the first cycle after release.
  - Reset mid-CLEAR/SCROLL/ESC aborts the operation immediately.
- Read path:
  - data is combinational from addr with no register stage; the driver samples it in the cycle after it presents addr.
  - Valid address: addr[7]=0 and addr[5:4]=00; line=addr[6], col=addr[3:0]. Any other address returns FILL_CHAR.
  - A read of a cell being written this cycle returns the old value; the new value is visible the next cycle.
- Handshake:
  - A byte is accepted at a posedge where in_valid&&in_ready.
  - in_ready=1 in IDLE and ESC, 0 in CLEAR and SCROLL.
  - in_data may change freely while in_ready=0.
- States:
  - IDLE:
    - Printable byte (0x20-0x7E or 0xA0-0xFF): written to cell[line][col], then the cursor advances.
    - 0x0D (CR): col <= 0.
    - 0x0A (LF): col <= 0 and line advance (see advance rule).
    - 0x08 (BS): col <= col-1, saturating at 0; cell unchanged.
    - 0x0C (FF): enter CLEAR.
    - ESC_CODE: enter ESC.
    - All other bytes: discarded, no state change.
  - ESC: next accepted byte b sets line <= b[4], col <= b[3:0]; b[7:5] ignored; return to IDLE. No cell write.
  - CLEAR:
    - 5-bit index 0..31 writes FILL_CHAR one cell per cycle (32 cycles).
    - On the cycle index=31 is written: cursor <= 0/0, next state IDLE, in_ready=1 on the following cycle.
  - SCROLL: with SCROLL_EN only; see Optional Feature.
- Cursor advance:
  - col 0..14 -> col+1.
  - col 15 on line 0 -> line 1, col 0.
  - col 15 on line 1 -> wrap or scroll per SCROLL_EN.
  - LF on line 0 -> line 1; LF on line 1 -> wrap/scroll rule.
- Arithmetic: col is a 4-bit counter; every wrap is explicit, never implicit overflow.
- Throughput: one byte per cycle in IDLE; no bubbles between back-to-back printable bytes.

Optional Feature:
- Macro: LCD_TEXT_BUFFER_SCROLL_EN.
- Defined (line-1 wrap/LF enters SCROLL):
  - For 16 cycles, i=0..15: cell[0][i] <= cell[1][i] and cell[1][i] <= FILL_CHAR.
  - Then cursor <= line 1, col 0; return to IDLE.
  - busy=1 and in_ready=0 throughout SCROLL.
- Undefined: line-1 wrap/LF sets cursor to line 0, col 0 with no data movement. SCROLL state and its counter are not built.

Test Plan:
- Reset, send "HI" back-to-back -> addr 0x00 reads 0x48, addr 0x01 reads 0x49, addr 0x02 reads 0x20; cursor 0/2; in_ready held 1.
- Send 17 x 'A' (0x41) -> cells 0x00-0x0F = 0x41, addr 0x40 = 0x41; cursor 1/1.
- Send 0x1B, 0x1A, 'Z' -> addr 0x4A = 0x5A; cursor 1/11. Read addr 0x20 -> 0x20 (out of map).
- Fill the buffer, send 0x0C -> in_ready=0 and busy=1 for exactly 32 cycles; all cells 0x20; cursor 0/0; a byte held valid during CLEAR is accepted only afterwards.
- Cursor at 1/15, send 'Q':
  - SCROLL_EN defined: 16-cycle busy; line 0 holds the old line 1 ending in 'Q'; line 1 all 0x20; cursor 1/0.
  - Undefined: cursor 0/0, no cell moves.
- Assert resetn=0 for one cycle mid-CLEAR and mid-ESC -> all cells 0x20, cursor 0/0, busy=0, in_ready=1 next cycle; a following byte is treated as a normal IDLE byte.
